muldiv_sequencer: RTL and testbench

- Multi-cycle controller and iterative datapath for the MULT/DIV operations decoded by the control unit.
- The main ALU stays single-cycle. When a MULT or DIV is issued, the core pulses start and holds issue while busy=1.
- Results land in HI/LO registers owned by this block.
- Sequences a shift-add multiply or restoring divide over WIDTH cycles, with signed pre/post fix-up.

---
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer: shift-add multiply and restoring divide over WIDTH
// iterations, with signed magnitude pre-conversion and sign fix-up into HI/LO.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_op, w_op_d;
  logic             r_sign_pq, w_sign_pq_d;
  logic             r_sign_r, w_sign_r_d;
  logic [WIDTH-1:0] r_opnd, w_opnd_d;
  logic [WIDTH-1:0] r_acc_hi, w_acc_hi_d;
  logic [WIDTH-1:0] r_acc_lo, w_acc_lo_d;
  logic [WIDTH-1:0] r_hi, w_hi_d;
  logic [WIDTH-1:0] r_lo, w_lo_d;
  logic             r_dbz, w_dbz_d;
  logic             r_busy, r_done;

  logic             w_accept;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic             w_div_zero;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub;
  logic [2*WIDTH-1:0] w_prod, w_prod_neg;
  logic [WIDTH-1:0] w_q_neg, w_r_neg;

  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;
  assign w_a_neg    = is_signed & a[WIDTH-1];
  assign w_b_neg    = is_signed & b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
  assign w_div_zero = op && (b == '0);

  // Multiply: {P_hi, P_lo} with |a| held in r_opnd; divide: {R, Q} with |b| in r_opnd.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_div_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_ge  = w_div_sh >= {1'b0, r_opnd};
  assign w_div_sub = w_div_sh[WIDTH-1:0] - r_opnd;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_neg = ~w_prod + 1'b1;
  assign w_q_neg    = ~r_acc_lo + 1'b1;
  assign w_r_neg    = ~r_acc_hi + 1'b1;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_op_d      = r_op;
    w_sign_pq_d = r_sign_pq;
    w_sign_r_d  = r_sign_r;
    w_opnd_d    = r_opnd;
    w_acc_hi_d  = r_acc_hi;
    w_acc_lo_d  = r_acc_lo;
    w_hi_d      = r_hi;
    w_lo_d      = r_lo;
    w_dbz_d     = r_dbz;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_d = S_IDLE;
        if (w_accept) begin
          w_op_d      = op;
          w_sign_pq_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          w_sign_r_d  = is_signed & a[WIDTH-1];
          w_opnd_d    = op ? w_b_mag : w_a_mag;
          w_acc_hi_d  = '0;
          w_acc_lo_d  = op ? w_a_mag : w_b_mag;
          w_cnt_d     = CNT_W'(WIDTH);
          if (w_div_zero) begin
            w_state_d = S_DONE;
            w_hi_d    = a;
            w_lo_d    = '1;
            w_dbz_d   = 1'b1;
          end else begin
            w_state_d = S_RUN;
            w_dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          w_state_d = S_IDLE;
        end else begin
          if (r_op) begin
            w_acc_hi_d = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
            w_acc_lo_d = {r_acc_lo[WIDTH-2:0], w_div_ge};
          end else begin
            w_acc_hi_d = w_mul_sum[WIDTH:1];
            w_acc_lo_d = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
          end
          w_cnt_d = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) w_state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          w_state_d = S_IDLE;
        end else begin
          w_state_d = S_DONE;
          if (r_op) begin
            w_lo_d = r_sign_pq ? w_q_neg : r_acc_lo;
            w_hi_d = r_sign_r ? w_r_neg : r_acc_hi;
          end else begin
            {w_hi_d, w_lo_d} = r_sign_pq ? w_prod_neg : w_prod;
          end
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= 1'b0;
      r_sign_pq <= 1'b0;
      r_sign_r  <= 1'b0;
      r_opnd    <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_op      <= w_op_d;
      r_sign_pq <= w_sign_pq_d;
      r_sign_r  <= w_sign_r_d;
      r_opnd    <= w_opnd_d;
      r_acc_hi  <= w_acc_hi_d;
      r_acc_lo  <= w_acc_lo_d;
      r_hi      <= w_hi_d;
      r_lo      <= w_lo_d;
      r_dbz     <= w_dbz_d;
      r_busy    <= (w_state_d == S_RUN) || (w_state_d == S_FIX);
      r_done    <= (w_state_d == S_DONE);
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed scenarios plus randomized ops checked
// against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail = 0;
  logic [64:0] exp_q[$];
  logic [64:0] last_exp = '0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Expected {div_by_zero, hi, lo} from the arithmetic definition of MULT/DIV.
  function automatic logic [64:0] model(input logic o, input logic s, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, q, r, p;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    if (o) begin
      if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
      q = sx / sy;
      r = sx % sy;
      return {1'b0, r[31:0], q[31:0]};
    end
    p = sx * sy;
    return {1'b0, p[63:32], p[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom();
    endcase
  endfunction

  task automatic push(input logic [64:0] e);
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y);
    op = o;
    is_signed = s;
    a = x;
    b = y;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 80 && !done; i++) step(1);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout got done=0 want done=1 within 80 cycles", name);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_b && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done got hi=%h lo=%h want no done", hi, lo);
      end else begin
        check("scoreboard", {div_by_zero, hi, lo}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s_o, s_s;
    logic [31:0] s_a, s_b;

    #12;
    check("reset_hilo", {1'b0, hi, lo}, 65'h0);
    check("reset_flags", {62'b0, busy, done, div_by_zero}, 65'h0);
    rst_b = 1'b1;
    step(1);

    // 1: unsigned max x max, latency and busy window
    push({1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c <= 34; c++) begin
      check($sformatf("t1_busy_done_cycle%0d", c), {63'b0, busy, done},
            {63'b0, (c <= 33), (c == 34)});
      if (c < 34) step(1);
    end
    step(1);

    // 2: signed and unsigned multiply
    push({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
    wait_done("t2a");
    step(1);
    push({1'b0, 32'h0000_0001, 32'h0});
    issue(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_done("t2b");
    step(1);

    // 3: signed and unsigned divide
    push({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("t3a");
    step(1);
    push({1'b0, 32'd2, 32'd14});
    issue(1'b1, 1'b0, 32'd100, 32'd7);
    wait_done("t3b");
    step(1);

    // 4: divide by zero finishes in one cycle, next start clears the flag
    push({1'b1, 32'd5, 32'hFFFF_FFFF});
    issue(1'b1, 1'b0, 32'd5, 32'd0);
    check("t4_dbz_cycle1", {63'b0, busy, done}, {63'b0, 1'b0, 1'b1});
    step(1);
    check("t4_idle_after", {63'b0, busy, done}, 65'h0);
    push({1'b0, 32'd0, 32'd30});
    issue(1'b0, 1'b0, 32'd6, 32'd5);
    check("t4_dbz_cleared", {64'b0, div_by_zero}, 65'h0);
    wait_done("t4b");
    step(1);

    // 5: ignored start while busy, flush, flush+start in idle
    issue(1'b0, 1'b0, 32'h1234, 32'h5678);
    step(4);
    op = 1'b1;
    a = 32'h9999;
    b = 32'h3;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("t5_flush_busy", {64'b0, busy}, 65'h0);
    check("t5_flush_hold", {div_by_zero, hi, lo}, last_exp);
    step(40);
    check("t5_no_done", {63'b0, busy, done}, 65'h0);
    check("t5_hold_late", {div_by_zero, hi, lo}, last_exp);
    start = 1'b1;
    flush = 1'b1;
    step(1);
    start = 1'b0;
    flush = 1'b0;
    check("t5_flush_start", {63'b0, busy, done}, 65'h0);
    step(3);
    check("t5_still_idle", {63'b0, busy, done}, 65'h0);

    // 6: asynchronous reset mid-run, signed overflow, back-to-back start from DONE
    issue(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1357_9BDF);
    step(5);
    #2;
    rst_b = 1'b0;
    #1;
    check("t6_reset_hilo", {1'b0, hi, lo}, 65'h0);
    check("t6_reset_flags", {62'b0, busy, done, div_by_zero}, 65'h0);
    #3;
    rst_b = 1'b1;
    step(1);
    push({1'b0, 32'h0, 32'h8000_0000});
    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("t6a");
    push({1'b0, 32'd0, 32'd12});
    issue(1'b0, 1'b0, 32'd3, 32'd4);
    check("t6_b2b_busy", {63'b0, busy, done}, {63'b0, 1'b1, 1'b0});
    wait_done("t6b");
    step(1);

    // Randomized operations, sometimes restarting straight from DONE
    for (int i = 0; i < 40; i++) begin
      s_o = 1'($urandom_range(0, 1));
      s_s = 1'($urandom_range(0, 1));
      s_a = pick();
      s_b = pick();
      push(model(s_o, s_s, s_a, s_b));
      issue(s_o, s_s, s_a, s_b);
      wait_done($sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) step(1);
    end
    step(3);
    check("scoreboard_drain", 65'(exp_q.size()), 65'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
